// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial sequencer that drives one combinational 1-bit ALU
// slice for WIDTH cycles, LSB first, and assembles a WIDTH-bit result with
// Zero/CarryOut flags.
// Optional feature: define ALU_SERIAL_OVF_EN to add the o_overflow port
// (signed overflow for ADD/SUB).
//
//   state  | meaning
//   S_IDLE | waiting for i_start; slice data inputs forced low
//   S_RUN  | presenting bit r_idx to the slice, capturing one result bit per clock
//   S_DONE | one-cycle Done pulse; i_start here chains straight into S_RUN
module alu_serial_seq #(
  parameter int WIDTH = 24
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_alu_op,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic             o_alu_a,
  output logic             o_alu_b,
  output logic             o_alu_cin,
  output logic             o_alu_binvert,
  output logic [1:0]       o_alu_op,
  input  logic             i_alu_result,
  input  logic             i_alu_cout,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
`ifdef ALU_SERIAL_OVF_EN
  output logic             o_overflow,
`endif
  output logic             o_carry_out
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry_out;
  logic             w_accept;
  logic             w_last;
  logic             w_run;
  logic             w_cin;
  logic [WIDTH-1:0] w_res_nxt;

  // Next-state decode; a Start is only honoured from IDLE or DONE.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        if (i_start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Slice drive and result assembly; bit 0 takes BInvert as carry-in so SUB is A + ~B + 1.
  always_comb begin
    w_run          = (r_state == S_RUN);
    w_last         = (r_idx == LAST_IDX);
    w_cin          = (r_idx == '0) ? r_op[2] : r_carry;
    o_alu_a        = w_run & r_a[r_idx];
    o_alu_b        = w_run & r_b[r_idx];
    o_alu_cin      = w_run & w_cin;
    o_alu_binvert  = r_op[2];
    o_alu_op       = r_op[1:0];
    w_res_nxt      = r_result;
    w_res_nxt[r_idx] = i_alu_result;
  end

  // Sequencer state, operand latches, bit counter and result/flag registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_carry_out <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a      <= i_op_a;
        r_b      <= i_op_b;
        r_op     <= i_alu_op;
        r_idx    <= '0;
        r_carry  <= 1'b0;
        r_result <= '0;
      end else if (w_run) begin
        r_result <= w_res_nxt;
        r_carry  <= i_alu_cout;
        if (w_last) begin
          r_zero      <= (w_res_nxt == '0);
          r_carry_out <= i_alu_cout;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

`ifdef ALU_SERIAL_OVF_EN
  logic r_overflow;

  // Signed overflow is carry-into xor carry-out of the MSB, meaningful only for ADD/SUB.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overflow <= 1'b0;
    end else if (w_run && w_last) begin
      r_overflow <= (r_op[1:0] == 2'b10) & (w_cin ^ i_alu_cout);
    end
  end

  assign o_overflow = r_overflow;
`endif

  assign o_busy      = (r_state == S_RUN);
  assign o_done      = (r_state == S_DONE);
  assign o_result    = r_result;
  assign o_zero      = r_zero;
  assign o_carry_out = r_carry_out;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Testbench for alu_serial_seq: behavioural 1-bit ALU slice, directed vector
// table, and hand-written sequences for mid-run Start, mid-run reset and
// back-to-back operation.
module tb_alu_serial_seq;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   aluop = '0;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic         alu_a, alu_b, alu_cin, alu_binv;
  logic [1:0]   alu_op;
  logic         alu_res, alu_cout;
  logic         busy, done, zero, carry;
  logic [W-1:0] result;
`ifdef ALU_SERIAL_OVF_EN
  logic         ovf;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_serial_seq #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_alu_op(aluop),
    .i_op_a(opa), .i_op_b(opb),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_cin(alu_cin),
    .o_alu_binvert(alu_binv), .o_alu_op(alu_op),
    .i_alu_result(alu_res), .i_alu_cout(alu_cout),
    .o_busy(busy), .o_done(done), .o_result(result), .o_zero(zero),
`ifdef ALU_SERIAL_OVF_EN
    .o_overflow(ovf),
`endif
    .o_carry_out(carry)
  );

  // ALU1 slice: B optionally inverted, full-adder carry out for every op.
  logic slice_b;
  always_comb begin
    slice_b  = alu_b ^ alu_binv;
    alu_cout = (alu_a & slice_b) | (alu_a & alu_cin) | (slice_b & alu_cin);
    case (alu_op)
      2'b00:   alu_res = alu_a & slice_b;
      2'b01:   alu_res = alu_a | slice_b;
      2'b10:   alu_res = alu_a ^ slice_b ^ alu_cin;
      default: alu_res = alu_a ^ slice_b;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one op and follow it; poke_at >= 0 pulses Start (or reset) after that bit.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int poke_at, input bit poke_rst,
                       output int n_done, output int n_busy, output bit cin0,
                       output bit busy_after, output logic [W-1:0] res_after);
    @(negedge clk);
    start = 1'b1; aluop = op; opa = a; opb = b;
    @(posedge clk); #1;
    start = 1'b0; aluop = ~op; opa = ~a; opb = b ^ 24'h5A5A5A;
    cin0 = alu_cin;
    n_busy = 0; n_done = -1; busy_after = 1'b0; res_after = 'x;
    for (int n = 0; n < 40; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      if (n == poke_at + 1) begin
        rst = 1'b0; start = 1'b0;
        busy_after = busy; res_after = result;
      end
      if (busy) n_busy++;
      if (done) begin
        n_done = n;
        break;
      end
      if (n == poke_at) begin
        if (poke_rst) rst = 1'b1;
        else start = 1'b1;
      end
    end
  endtask

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         c;
    bit           c_care;
    logic         v;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int nd, nb, nd1;
    bit c0, ba;
    logic [W-1:0] ra;

    vecs[0] = '{"add_f_1",    3'b010, 24'h00000F, 24'h000001, 24'h000010, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{"sub_5_5",    3'b110, 24'h000005, 24'h000005, 24'h000000, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{"add_wrap",   3'b010, 24'hFFFFFF, 24'h000001, 24'h000000, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{"add_ovf",    3'b010, 24'h7FFFFF, 24'h000001, 24'h800000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{"xor",        3'b011, 24'hAAAAAA, 24'hFFFFFF, 24'h555555, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{"and",        3'b000, 24'hF0F0F0, 24'h3C3C3C, 24'h303030, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{"or",         3'b001, 24'hF00000, 24'h00000F, 24'hF0000F, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{"and_notb",   3'b100, 24'hFFFFFF, 24'h0000FF, 24'hFFFF00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{"sub_3_5",    3'b110, 24'h000003, 24'h000005, 24'hFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{"add_0_0",    3'b010, 24'h000000, 24'h000000, 24'h000000, 1'b1, 1'b0, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   32'(busy),   32'h0);
    chk("rst_done",   32'(done),   32'h0);
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_zero",   32'(zero),   32'h0);
    chk("rst_carry",  32'(carry),  32'h0);
    chk("rst_aluop",  32'({alu_binv, alu_op}), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, 1'b0, nd, nb, c0, ba, ra);
      chk({vecs[i].name, "_latency"}, 32'(nd), 32'(W));
      chk({vecs[i].name, "_busy"},    32'(nb), 32'(W));
      chk({vecs[i].name, "_cin0"},    32'(c0), 32'(vecs[i].op[2]));
      chk({vecs[i].name, "_result"},  32'(result), 32'(vecs[i].res));
      chk({vecs[i].name, "_zero"},    32'(zero), 32'(vecs[i].z));
      if (vecs[i].c_care) chk({vecs[i].name, "_carry"}, 32'(carry), 32'(vecs[i].c));
`ifdef ALU_SERIAL_OVF_EN
      chk({vecs[i].name, "_ovf"},     32'(ovf), 32'(vecs[i].v));
`endif
    end

    // Start pulsed at bit 5 of an ADD is ignored.
    do_op(3'b010, 24'h001234, 24'h000111, 5, 1'b0, nd, nb, c0, ba, ra);
    chk("midstart_latency", 32'(nd), 32'(W));
    chk("midstart_result",  32'(result), 32'h001345);
    @(posedge clk); #1;
    chk("midstart_idle", 32'(busy), 32'h0);

    // Reset at bit 10 aborts with no Done.
    do_op(3'b010, 24'h0ABCDE, 24'h012345, 10, 1'b1, nd, nb, c0, ba, ra);
    chk("reset_busy",   32'(ba), 32'h0);
    chk("reset_result", 32'(ra), 32'h0);
    chk("reset_nodone", nd, 32'hFFFFFFFF);
    do_op(3'b010, 24'h000001, 24'h000002, -1, 1'b0, nd, nb, c0, ba, ra);
    chk("after_rst_latency", 32'(nd), 32'(W));
    chk("after_rst_result",  32'(result), 32'h000003);

    // Start held high through Done: back-to-back ops.
    @(negedge clk);
    start = 1'b1; aluop = 3'b010; opa = 24'h00000A; opb = 24'h000014;
    @(posedge clk); #1;
    aluop = 3'b110; opa = 24'h000064; opb = 24'h000001;
    nd1 = -1;
    for (int n = 0; n < 40; n++) begin
      if (done) begin
        nd1 = n;
        break;
      end
      @(posedge clk); #1;
    end
    chk("b2b_first_latency", 32'(nd1), 32'(W));
    chk("b2b_first_result",  32'(result), 32'h00001E);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_rerun_busy",   32'(busy), 32'h1);
    chk("b2b_rerun_clear",  32'(result), 32'h0);
    nd = -1;
    for (int n = 1; n < 40; n++) begin
      if (done) begin
        nd = n;
        break;
      end
      @(posedge clk); #1;
    end
    chk("b2b_done_spacing", 32'(nd), 32'(W + 1));
    chk("b2b_second_result", 32'(result), 32'h000063);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
